// File: rtl/small_sync_fifo.sv
// ---------------------------------------------------------------------------
// small_sync_fifo
//
// Single-clock first-word-fall-through byte FIFO. Words are held in a
// RAM-inferable array of 2^A_WIDTH entries and presented through a one-word
// registered output stage, so the head of the queue is always on dout while
// empty is low. Total capacity is 2^A_WIDTH + 1 words.
//
// Ports:
//   CLK    in   clock, all state updates on the rising edge
//   rst    in   asynchronous active-high reset
//   din    in   write data
//   wr_en  in   write request, ignored while full
//   full   out  RAM section holds 2^A_WIDTH words
//   dout   out  head-of-queue word, valid while empty = 0
//   rd_en  in   pop request, consumes dout at this edge, ignored while empty
//   empty  out  no valid word on dout
//   count  out  words held, including the output stage
// ---------------------------------------------------------------------------
module small_sync_fifo #(
   parameter int A_WIDTH = 12,
   parameter int D_WIDTH = 8
) (
   input  logic               CLK,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] din,
   input  logic               wr_en,
   output logic               full,
   output logic [D_WIDTH-1:0] dout,
   input  logic               rd_en,
   output logic               empty,
   output logic [A_WIDTH:0]   count
);

   localparam int DEPTH = 1 << A_WIDTH;

   logic [D_WIDTH-1:0] mem [DEPTH];

   // Pointers carry one extra MSB so a full RAM section (low bits equal,
   // MSB different) is distinguishable from an empty one (all bits equal).
   logic [A_WIDTH:0] wr_ptr, rd_ptr;
   logic [A_WIDTH:0] wr_ptr_nxt, rd_ptr_nxt;
   logic [A_WIDTH:0] count_nxt;
   logic             ram_empty;
   logic             wr_acc, rd_acc, load;
   logic             full_nxt, empty_nxt;

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      ram_empty  = (wr_ptr == rd_ptr);
      wr_acc     = wr_en & ~full;
      rd_acc     = rd_en & ~empty;
      // Refill the output stage when it is vacant or being popped this edge.
      // The RAM word at rd_ptr was written at least one edge earlier, so a
      // load never reads the address being written in the same cycle.
      load       = ~ram_empty & (empty | rd_acc);
      wr_ptr_nxt = wr_ptr + (A_WIDTH+1)'(wr_acc);
      rd_ptr_nxt = rd_ptr + (A_WIDTH+1)'(load);
      full_nxt   = (wr_ptr_nxt[A_WIDTH] != rd_ptr_nxt[A_WIDTH]) &&
                   (wr_ptr_nxt[A_WIDTH-1:0] == rd_ptr_nxt[A_WIDTH-1:0]);

      empty_nxt = empty;
      if (load)        empty_nxt = 1'b0;
      else if (rd_acc) empty_nxt = 1'b1;

      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + (A_WIDTH+1)'(1);
         2'b01:   count_nxt = count - (A_WIDTH+1)'(1);
         default: count_nxt = count;
      endcase
   end

   // NOTE: the storage array has no reset so it can map onto block RAM; stale
   // contents are unreachable because reset clears both pointers.
   always_ff @(posedge CLK) begin
      if (wr_acc) mem[wr_ptr[A_WIDTH-1:0]] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed above.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         count  <= '0;
         dout   <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         full   <= full_nxt;
         empty  <= empty_nxt;
         count  <= count_nxt;
         if (load) dout <= mem[rd_ptr[A_WIDTH-1:0]];
      end
   end

endmodule

// File: tb/tb_small_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_small_sync_fifo
//
// Self-checking bench for small_sync_fifo with A_WIDTH = 3 (9-word capacity).
// A scoreboard queue holds every accepted word together with the edge it was
// written on; the head becomes visible on dout one edge after its write.
// ---------------------------------------------------------------------------
module tb_small_sync_fifo;

   localparam int AW  = 3;
   localparam int DW  = 8;
   localparam int CAP = (1 << AW) + 1;

   logic          CLK = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] din = '0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          full, empty;
   logic [DW-1:0] dout;
   logic [AW:0]   count;

   small_sync_fifo #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
      .CLK   (CLK),
      .rst   (rst),
      .din   (din),
      .wr_en (wr_en),
      .full  (full),
      .dout  (dout),
      .rd_en (rd_en),
      .empty (empty),
      .count (count)
   );

   always #5 CLK = ~CLK;

   int edge_n = 0;
   always @(posedge CLK) edge_n <= edge_n + 1;

   typedef struct {
      logic [DW-1:0] data;
      int            wedge;
   } entry_t;

   entry_t sb[$];
   int     n_checks = 0;
   int     n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_empty();
      return (sb.size() == 0) || (sb[0].wedge == edge_n);
   endfunction

   // One clock cycle: drive inputs, let the edge pass, update the model and
   // compare flags, count and head. Called #1 after an edge.
   task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
      bit w_acc, r_acc;
      w_acc = w && (sb.size() < CAP);
      r_acc = r && !model_empty();
      if (r_acc) check("pop_data", dout, sb[0].data);
      wr_en = w;
      din   = d;
      rd_en = r;
      @(posedge CLK);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      if (r_acc) void'(sb.pop_front());
      if (w_acc) sb.push_back('{data: d, wedge: edge_n});
      check("empty", empty, model_empty());
      check("full",  full,  sb.size() == CAP);
      check("count", count, sb.size());
      if (!model_empty()) check("head", dout, sb[0].data);
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         cycle(1'b0, '0, !empty);
         guard++;
      end
      check({tag, "_drained"}, sb.size(), 0);
   endtask

   logic [DW-1:0] stream [8] = '{8'h02, 8'h03, 8'h00, 8'h00, 8'h37, 8'h00, 8'hAB, 8'hCD};

   initial begin
      // Test 1: reset and idle.
      repeat (3) @(posedge CLK);
      #1 rst = 1'b0;
      check("rst_empty", empty, 1);
      check("rst_full",  full,  0);
      check("rst_count", count, 0);
      check("rst_dout",  dout,  0);
      cycle(1'b0, '0, 1'b0);
      check("idle_dout", dout, 0);

      // Asynchronous reset mid-stream after five writes.
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'h50 + DW'(i), 1'b0);
      #3 rst = 1'b1;
      #1;
      check("arst_empty", empty, 1);
      check("arst_full",  full,  0);
      check("arst_count", count, 0);
      check("arst_dout",  dout,  0);
      sb.delete();
      @(posedge CLK);
      #1 rst = 1'b0;
      cycle(1'b1, 8'h77, 1'b0);
      cycle(1'b0, '0, 1'b0);
      check("arst_post_data", dout, 8'h77);
      drain("t1");

      // Test 2: two-edge write-to-visible latency, pop, then underflow.
      cycle(1'b1, 8'h02, 1'b0);
      check("lat_e_empty", empty, 1);
      cycle(1'b0, '0, 1'b0);
      check("lat_e1_empty", empty, 0);
      check("lat_e1_dout",  dout,  8'h02);
      check("lat_e1_count", count, 1);
      cycle(1'b0, '0, 1'b1);
      check("pop_empty", empty, 1);
      check("pop_count", count, 0);
      cycle(1'b0, '0, 1'b1);
      check("underflow_dout",  dout,  8'h02);
      check("underflow_count", count, 0);

      // Test 3: back-to-back stream, reading whenever a word is visible.
      for (int i = 0; i < 8; i++) cycle(1'b1, stream[i], !empty);
      drain("t3");

      // Test 4: fill past capacity, ten writes, word 10 dropped.
      for (int i = 1; i <= 10; i++) cycle(1'b1, DW'(i), 1'b0);
      check("fill_full",  full,  1);
      check("fill_count", count, CAP);
      drain("t4");
      check("t4_empty", empty, 1);

      // Test 5: simultaneous write and read while full.
      for (int i = 1; i <= 9; i++) cycle(1'b1, DW'(i), 1'b0);
      check("t5_pre_full", full, 1);
      check("t5_pre_head", dout, 8'h01);
      cycle(1'b1, 8'hEE, 1'b1);
      check("t5_count", count, CAP - 1);
      check("t5_full",  full,  0);
      check("t5_head",  dout,  8'h02);
      drain("t5");

      // Test 6: 40 words with random gaps, pointers wrap several times.
      begin
         int sent = 0;
         int guard = 0;
         while ((sent < 40 || sb.size() != 0) && guard < 2000) begin
            bit w, r;
            w = (sent < 40) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 1) != 0);
            if (w && sb.size() < CAP) begin
               cycle(1'b1, DW'(sent % 256), r);
               sent++;
            end else begin
               cycle(w, DW'(sent % 256), r);
            end
            guard++;
         end
         check("t6_sent",    sent, 40);
         check("t6_drained", sb.size(), 0);
         check("t6_empty",   empty, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
